// File: rtl/fib_pkg.sv
// Shared types and sizing for the FIB lookup front end.
package fib_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int MAX_NAME_LENGTH = 8;
    localparam int LEN_WIDTH       = $clog2(MAX_NAME_LENGTH) + 1;
    localparam int IDX_WIDTH       = $clog2(MAX_NAME_LENGTH);

    typedef logic [WORD_SIZE-1:0] name_word_t;
    typedef name_word_t name_vec_t [MAX_NAME_LENGTH];

    typedef enum logic [1:0] {
        FILL,
        DISCARD,
        HOLD
    } asm_state_t;

endpackage

// File: rtl/name_out_reg.sv
// Single-entry holding register for an assembled name vector plus length/trunc.
// Latency: a load on edge N is presented as valid in cycle N+1.
// Backpressure: holds contents stable until name_ready_in; a load may replace a draining entry.
module name_out_reg
    import fib_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 loadValid,
    input  logic [WORD_SIZE-1:0] loadName [MAX_NAME_LENGTH],
    input  logic [LEN_WIDTH-1:0] loadLen,
    input  logic                 loadTrunc,
    output logic                 full,
    output logic                 willDrain,
    output logic [WORD_SIZE-1:0] name_out [MAX_NAME_LENGTH],
    output logic [LEN_WIDTH-1:0] name_len_out,
    output logic                 name_trunc_out,
    output logic                 name_valid_out,
    input  logic                 name_ready_in
);

    assign full      = name_valid_out;
    assign willDrain = name_valid_out && name_ready_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            name_valid_out <= 1'b0;
            name_len_out   <= '0;
            name_trunc_out <= 1'b0;
            for (int i = 0; i < MAX_NAME_LENGTH; i++) begin
                name_out[i] <= '0;
            end
        end else if (loadValid) begin
            name_valid_out <= 1'b1;
            name_len_out   <= loadLen;
            name_trunc_out <= loadTrunc;
            for (int i = 0; i < MAX_NAME_LENGTH; i++) begin
                name_out[i] <= loadName[i];
            end
        end else if (willDrain) begin
            name_valid_out <= 1'b0;
        end
    end

endmodule

// File: rtl/name_assembler.sv
// Collects a stream of name words into a zero-padded parallel name vector.
// Latency: last word accepted on edge N -> name_valid_out in cycle N+1.
// Backpressure: one assembly buffer plus one output register; word_ready_out drops only in HOLD.
module name_assembler
    import fib_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] word_in,
    input  logic                 word_valid_in,
    input  logic                 word_last_in,
    output logic                 word_ready_out,
    output logic [WORD_SIZE-1:0] name_out [MAX_NAME_LENGTH],
    output logic [LEN_WIDTH-1:0] name_len_out,
    output logic                 name_trunc_out,
    output logic                 name_valid_out,
    input  logic                 name_ready_in
);

    asm_state_t           state;
    asm_state_t           stateNext;
    logic [IDX_WIDTH-1:0] idx;
    name_vec_t            asmBuf;
    name_vec_t            candBuf;
    name_vec_t            loadName;
    logic [LEN_WIDTH-1:0] asmLen;
    logic [LEN_WIDTH-1:0] loadLen;
    logic                 asmTrunc;
    logic                 loadTrunc;
    logic                 wordFire;
    logic                 bufWrite;
    logic                 complete;
    logic                 doLoad;
    logic                 outFull;
    logic                 outWillDrain;
    logic                 canLoad;

    assign word_ready_out = (state != HOLD);
    assign wordFire       = word_valid_in && word_ready_out;
    assign canLoad        = !outFull || outWillDrain;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        bufWrite  = 1'b0;
        complete  = 1'b0;
        doLoad    = 1'b0;
        loadLen   = LEN_WIDTH'(idx) + LEN_WIDTH'(1);
        loadTrunc = 1'b0;
        unique case (state)
            FILL: begin
                if (wordFire) begin
                    bufWrite = 1'b1;
                    if (word_last_in) begin
                        complete = 1'b1;
                    end else if (idx == IDX_WIDTH'(MAX_NAME_LENGTH - 1)) begin
                        stateNext = DISCARD;
                    end
                end
            end
            DISCARD: begin
                loadLen   = LEN_WIDTH'(MAX_NAME_LENGTH);
                loadTrunc = 1'b1;
                if (wordFire && word_last_in) begin
                    complete = 1'b1;
                end
            end
            HOLD: begin
                loadLen   = asmLen;
                loadTrunc = asmTrunc;
                if (canLoad) begin
                    doLoad    = 1'b1;
                    stateNext = FILL;
                end
            end
            default: stateNext = FILL;
        endcase
        if (complete) begin
            if (canLoad) begin
                doLoad    = 1'b1;
                stateNext = FILL;
            end else begin
                stateNext = HOLD;
            end
        end
    end

    // The completing word bypasses the buffer; slots past the length are masked
    // so stale words from a longer earlier name never leak out.
    always_comb begin
        for (int i = 0; i < MAX_NAME_LENGTH; i++) begin
            candBuf[i]  = (bufWrite && idx == IDX_WIDTH'(i)) ? word_in : asmBuf[i];
            loadName[i] = (LEN_WIDTH'(i) < loadLen) ? candBuf[i] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            asmLen   <= '0;
            asmTrunc <= 1'b0;
            for (int i = 0; i < MAX_NAME_LENGTH; i++) begin
                asmBuf[i] <= '0;
            end
        end else begin
            if (bufWrite) begin
                asmBuf[idx] <= word_in;
            end
            if (complete) begin
                idx      <= '0;
                asmLen   <= loadLen;
                asmTrunc <= loadTrunc;
            end else if (bufWrite && idx != IDX_WIDTH'(MAX_NAME_LENGTH - 1)) begin
                idx <= idx + IDX_WIDTH'(1);
            end
        end
    end

    name_out_reg u_outReg (
        .clk            (clk),
        .rst            (rst),
        .loadValid      (doLoad),
        .loadName       (loadName),
        .loadLen        (loadLen),
        .loadTrunc      (loadTrunc),
        .full           (outFull),
        .willDrain      (outWillDrain),
        .name_out       (name_out),
        .name_len_out   (name_len_out),
        .name_trunc_out (name_trunc_out),
        .name_valid_out (name_valid_out),
        .name_ready_in  (name_ready_in)
    );

endmodule

// File: tb/tb_name_assembler.sv
// Scoreboard bench for name_assembler: reference model builds expected names from accepted words.
module tb_name_assembler;

    logic        clk;
    logic        rst;
    logic [31:0] word_in;
    logic        word_valid_in;
    logic        word_last_in;
    logic        word_ready_out;
    logic [31:0] name_out [8];
    logic [3:0]  name_len_out;
    logic        name_trunc_out;
    logic        name_valid_out;
    logic        name_ready_in;

    name_assembler dut (
        .clk            (clk),
        .rst            (rst),
        .word_in        (word_in),
        .word_valid_in  (word_valid_in),
        .word_last_in   (word_last_in),
        .word_ready_out (word_ready_out),
        .name_out       (name_out),
        .name_len_out   (name_len_out),
        .name_trunc_out (name_trunc_out),
        .name_valid_out (name_valid_out),
        .name_ready_in  (name_ready_in)
    );

    typedef struct {
        logic [31:0] w [8];
        int          len;
        bit          trunc;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] part [$];
    int          total = 0;
    int          bad = 0;
    int          rdyMode = 1;  // 0: hold low, 1: hold high, 2: random

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic checkVec(input string nm, input logic [31:0] act [8], input logic [31:0] exp [8]);
        int firstBad;
        firstBad = -1;
        for (int i = 0; i < 8; i++) begin
            if (act[i] !== exp[i] && firstBad < 0) firstBad = i;
        end
        total++;
        if (firstBad >= 0) begin
            bad++;
            $display("FAIL %s: slot %0d got 0x%0h expected 0x%0h at %0t",
                     nm, firstBad, act[firstBad], exp[firstBad], $time);
        end
    endtask

    // name_ready_in driver
    initial begin
        name_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdyMode)
                0: name_ready_in = 1'b0;
                1: name_ready_in = 1'b1;
                default: name_ready_in = ($urandom_range(0, 9) < 6);
            endcase
        end
    end

    // Monitor and reference model, sampled on the falling edge.
    initial begin
        logic [31:0] prevName [8];
        logic [3:0]  prevLen;
        logic        prevTrunc;
        bit          prevStall;
        exp_t        e;
        exp_t        got;
        int          n;
        prevStall = 0;
        prevLen = '0;
        prevTrunc = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                part.delete();
                prevStall = 0;
            end else begin
                check("word_ready_out", {31'b0, word_ready_out}, {31'b0, sb.size() < 2});
                check("name_valid_out", {31'b0, name_valid_out}, {31'b0, sb.size() > 0});
                if (prevStall && name_valid_out) begin
                    checkVec("stable_name", name_out, prevName);
                    check("stable_len", {28'b0, name_len_out}, {28'b0, prevLen});
                    check("stable_trunc", {31'b0, name_trunc_out}, {31'b0, prevTrunc});
                end
                if (name_valid_out && name_ready_in) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_name: got name len %0d expected none", name_len_out);
                    end else begin
                        e = sb.pop_front();
                        got.w = name_out;
                        checkVec("name_out", got.w, e.w);
                        check("name_len_out", {28'b0, name_len_out}, e.len);
                        check("name_trunc_out", {31'b0, name_trunc_out}, {31'b0, e.trunc});
                    end
                end
                if (word_valid_in && word_ready_out) begin
                    part.push_back(word_in);
                    if (word_last_in) begin
                        n = part.size();
                        for (int i = 0; i < 8; i++) e.w[i] = (i < n) ? part[i] : 32'h0;
                        e.len   = (n > 8) ? 8 : n;
                        e.trunc = (n > 8);
                        sb.push_back(e);
                        part.delete();
                    end
                end
                prevStall = name_valid_out && !name_ready_in;
                prevName  = name_out;
                prevLen   = name_len_out;
                prevTrunc = name_trunc_out;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendWord(input logic [31:0] w, input logic last);
        int guard;
        guard = 0;
        word_in       = w;
        word_last_in  = last;
        word_valid_in = 1'b1;
        @(negedge clk);
        while (!word_ready_out && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL word_accept_timeout: got ready=0 expected ready=1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        word_valid_in = 1'b0;
        word_last_in  = 1'($urandom);
        word_in       = $urandom;
    endtask

    task automatic sendName(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) sendWord(base + 32'(i), i == n - 1);
    endtask

    initial begin
        int guard;
        int len;
        rst           = 1'b1;
        word_in       = '0;
        word_valid_in = 1'b0;
        word_last_in  = 1'b0;
        rdyMode       = 1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", {31'b0, name_valid_out}, 32'h0);
        check("reset_len", {28'b0, name_len_out}, 32'h0);
        check("reset_trunc", {31'b0, name_trunc_out}, 32'h0);
        check("reset_ready", {31'b0, word_ready_out}, 32'h1);
        for (int i = 0; i < 8; i++) check("reset_name", name_out[i], 32'h0);
        @(posedge clk);
        #1;

        // 3-word name
        sendWord(32'hA, 0); sendWord(32'hB, 0); sendWord(32'hC, 1);
        idle(3);
        // 11-word name, truncated to 8
        sendName(11, 32'd1);
        idle(3);
        // back-pressure: second name parks in the assembly buffer
        rdyMode = 0;
        idle(1);
        sendWord(32'd5, 0); sendWord(32'd6, 1); sendWord(32'd7, 1);
        idle(4);
        @(negedge clk);
        check("hold_ready", {31'b0, word_ready_out}, 32'h0);
        @(posedge clk);
        #1;
        rdyMode = 1;
        idle(4);
        // streaming 1-word names
        for (int i = 0; i < 8; i++) sendWord(32'h10 + 32'(i), 1);
        idle(3);
        // reset mid-name
        sendWord(32'hAA, 0); sendWord(32'hBB, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        sendWord(32'hCC, 1);
        idle(3);
        // padding after a full-length name
        sendName(8, 32'hF1);
        sendWord(32'h1, 0); sendWord(32'h2, 1);
        idle(3);

        // randomized names and back-pressure
        rdyMode = 2;
        for (int k = 0; k < 300; k++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) sendWord($urandom, i == len - 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        rdyMode = 1;
        guard = 0;
        while ((sb.size() != 0 || name_valid_out) && guard < 100) begin
            idle(1);
            guard++;
        end
        check("drain_empty", sb.size(), 32'h0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/name_assembler.md
Name: name_assembler

Overview:
- Upstream feeder for the FIB lookup pipeline.
- Accepts an NDN name as a stream of 32-bit component words with a last flag.
- Assembles the words into the pipeline's parallel name vector (MAX_NAME_LENGTH words), zero-pads unused words, and presents one complete name per transfer over a valid/ready handshake.
- Absorbs back-pressure from the pipeline issue logic with one assembly buffer plus one output holding register.

Parameters:
- WORD_SIZE, 32, width of one name component word
- MAX_NAME_LENGTH, 8, words per name vector; must be a power of two, at least 2
- LEN_WIDTH, 4, width of the length field, equal to $clog2(MAX_NAME_LENGTH)+1

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- word_in  input  WORD_SIZE  next name word
- word_valid_in  input  1  word_in is valid
- word_last_in  input  1  word_in is the final word of the name
- word_ready_out  output  1  block accepts word this cycle
- name_out  output  WORD_SIZE x MAX_NAME_LENGTH (unpacked array)  assembled name; word 0 is the first received
- name_len_out  output  LEN_WIDTH  words stored, range 1..MAX_NAME_LENGTH
- name_trunc_out  output  1  name exceeded MAX_NAME_LENGTH and was truncated
- name_valid_out  output  1  name_out, name_len_out and name_trunc_out are valid
- name_ready_in  input  1  pipeline takes the name this cycle

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset state:
  - name_valid_out=0, name_len_out=0, name_trunc_out=0.
  - name_out all zero; assembly buffer all zero; word index 0.
  - FSM in FILL.
  - word_ready_out=1 in the first cycle after reset is released.
- Word transfer: occurs when word_valid_in && word_ready_out.
- Name transfer: occurs when name_valid_out && name_ready_in.
- FSM state FILL:
  - Each accepted word is written to assembly slot idx, then idx increments.
  - Word with last=1 at idx<=MAX-1: the name completes with len=idx+1.
  - Word without last at idx=MAX-1: stored, then the FSM goes to DISCARD with trunc=1.
- FSM state DISCARD:
  - word_ready_out=1; accepted words are dropped.
  - A word with last=1 completes the name with len=MAX and trunc=1.
- FSM state HOLD:
  - The name is complete but the output register is occupied and not being drained.
  - word_ready_out=0.
  - Leaves HOLD when the output register frees; the name moves to output, then the FSM goes to FILL.
- Completion, same-cycle path:
  - Applies when the output register is empty, or a name transfer occurs in the same cycle.
  - The assembly buffer, with unused slots forced to 0, is copied to name_out with len and trunc.
  - name_valid_out=1 on the next edge; idx is cleared and the FSM goes to FILL.
- Completion otherwise: the FSM goes to HOLD.
- Latency: last word accepted on edge N gives name_valid_out=1 after edge N, visible in cycle N+1.
- Throughput: with name_ready_in held 1, one-word names sustain 1 name per cycle.
- word_ready_out is combinational from state only (FILL/DISCARD=1, HOLD=0). It has no combinational dependence on name_ready_in.
- Output stability:
  - name_out, len and trunc stay constant while name_valid_out=1 and name_ready_in=0.
  - name_valid_out falls only after a name transfer with no replacement ready.
- Zero padding: slots at index >= len are 0, regardless of earlier names.
- Reset mid-name: the partial name is discarded, and any held or valid output is dropped without handshake.
- word_last_in with word_valid_in=0 is ignored.

Decomposition:
- Package fib_pkg holds:
  - constants WORD_SIZE, MAX_NAME_LENGTH, LEN_WIDTH
  - typedef name_word_t
  - typedef name_vec_t (unpacked array of MAX_NAME_LENGTH words)
  - enum asm_state_t {FILL, DISCARD, HOLD}
- One sub-module, name_out_reg: a single-entry valid/ready holding register for name_vec_t plus len/trunc. It exposes full and will_drain to the FSM.

Test Plan:
- Name 3-word:
  - Stimulus: reset, then words 0xA, 0xB, 0xC (last on 0xC), ready_in=1.
  - Required: one cycle after 0xC, valid=1, name_out={A,B,C,0,0,0,0,0}, len=3, trunc=0.
- Name 11-word:
  - Stimulus: words 1..11, last on 11.
  - Required: words 1..8 stored, len=8, trunc=1; word_ready_out stays 1 through words 9..11.
- Name back-to-back with back-pressure:
  - Stimulus: ready_in=0; send a 2-word name (5,6), then a 1-word name (7).
  - Required: first name holds stable; word_ready_out=0 after 7 is accepted (HOLD). Raising ready_in yields {5,6}, then {7,0,...} on the next cycle.
- Name streaming:
  - Stimulus: 1-word names 0x10..0x17 every cycle, ready_in=1.
  - Required: 8 consecutive valid cycles, name_out[0]=0x10..0x17, len=1 each.
- Reset mid-name:
  - Stimulus: accept 0xAA, 0xBB, assert rst one cycle, then send 0xCC with last.
  - Required: output {CC,0,...}, len=1; 0xAA and 0xBB never appear.
- Name padding:
  - Stimulus: an 8-word name 0xF1..0xF8, then a 2-word name 0x1, 0x2.
  - Required: second output is {1,2,0,0,0,0,0,0}, len=2; no stale 0xF3..0xF8 words.
